// File: rtl/sync_pkg.sv
// Shared definitions for the data synchronizer: FSM state encoding and the
// default depth of the enable synchronizer.
package sync_pkg;

  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sync_state_e;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a bus of independent single-bit signals.
// Each bit is resynchronized on its own; it is not a coherent data path.
module bit_synchronizer
  import sync_pkg::*;
#(
  parameter int NUM_OF_STAGE = DEFAULT_SYNC_STAGES,
  parameter int WIDTH        = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] unsync_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [NUM_OF_STAGE-1:0][WIDTH-1:0] stages_q;

  // Stage 0 takes the asynchronous input; the last stage is the settled value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stages_q <= '0;
    end else begin
      stages_q <= {stages_q[NUM_OF_STAGE-2:0], unsync_i};
    end
  end

  assign sync_o = stages_q[NUM_OF_STAGE-1];

endmodule

// File: rtl/data_synchronizer.sv
// Enable-qualified bus synchronizer: only the request level crosses through
// flops; the data bus is captured once the synchronized request rises.
module data_synchronizer
  import sync_pkg::*;
#(
  parameter int NUM_OF_STAGE = DEFAULT_SYNC_STAGES,
  parameter int WIDTH        = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] unsync_bus,
  input  logic             bus_enable,
  output logic [WIDTH-1:0] sync_bus,
  output logic             enable_pulse,
  output logic             ack
);

  logic             sync_en;
  logic             sync_en_prev_q;
  sync_state_e      state_q, state_d;
  logic [WIDTH-1:0] sync_bus_q, sync_bus_d;
  logic             pulse_q, pulse_d;
  logic             ack_q, ack_d;

  bit_synchronizer #(
    .NUM_OF_STAGE (NUM_OF_STAGE),
    .WIDTH        (1)
  ) u_enable_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .unsync_i (bus_enable),
    .sync_o   (sync_en)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_en_prev_q <= 1'b0;
      state_q        <= IDLE;
      sync_bus_q     <= '0;
      pulse_q        <= 1'b0;
      ack_q          <= 1'b0;
    end else begin
      sync_en_prev_q <= sync_en;
      state_q        <= state_d;
      sync_bus_q     <= sync_bus_d;
      pulse_q        <= pulse_d;
      ack_q          <= ack_d;
    end
  end

  // The source holds unsync_bus stable while its request is high, so the bus
  // is safe to sample directly on the synchronized rising edge.
  always_comb begin
    state_d    = state_q;
    sync_bus_d = sync_bus_q;
    pulse_d    = 1'b0;
    ack_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_en && !sync_en_prev_q) begin
          state_d    = BUSY;
          sync_bus_d = unsync_bus;
          pulse_d    = 1'b1;
          ack_d      = 1'b1;
        end
      end
      BUSY: begin
        ack_d = 1'b1;
        if (!sync_en) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sync_bus     = sync_bus_q;
  assign enable_pulse = pulse_q;
  assign ack          = ack_q;

endmodule
